// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns, FSM states and BCD sizing shared by the seven-segment display controller
package seg7_pkg;
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0001100;
  localparam logic [6:0] SEG_MINUS = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
  function automatic int bcd_n(input int w);
    return (w * 30103) / 100000 + 1;
  endfunction
endpackage

// File: rtl/seg7_encode.sv
// seg7_encode: one BCD nibble plus blank flag to an active-low a..g pattern; codes 10..15 show 'E'
module seg7_encode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);
  // blank wins over the digit value
  always_comb
    if (blank) seg = SEG_BLANK;
    else
      case (bcd)
        4'd0: seg = SEG_0;
        4'd1: seg = SEG_1;
        4'd2: seg = SEG_2;
        4'd3: seg = SEG_3;
        4'd4: seg = SEG_4;
        4'd5: seg = SEG_5;
        4'd6: seg = SEG_6;
        4'd7: seg = SEG_7;
        4'd8: seg = SEG_8;
        4'd9: seg = SEG_9;
        default: seg = SEG_E;
      endcase
endmodule

// File: rtl/seg7_display_ctrl.sv
// seg7_display_ctrl: iterative double-dabble binary-to-decimal seven-segment driver; SEG7_BLANK_LEADING_ZEROS_EN blanks leading zeros
module seg7_display_ctrl
  import seg7_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  update,
  input  logic [DATA_W-1:0]     value,
  input  logic                  signed_mode,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);
  localparam int BCD_N = bcd_n(DATA_W);
  localparam int BW = 4 * BCD_N;
  localparam int PN = BCD_N > DIGITS - 1 ? BCD_N : DIGITS - 1;
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [7*DIGITS-1:0] RST_SEG = {SEG_BLANK, {(DIGITS - 1){SEG_0}}};
  state_t st;
  logic sign, pend, p_sm;
  logic [DATA_W-1:0] mag, p_val;
  logic [BW-1:0] bcd, adj, nb;
  logic [CW-1:0] cnt;
  logic [4*PN-1:0] pb;
  logic [DIGITS-2:0] blk;
  logic [7*(DIGITS-1)-1:0] enc_flat;
  logic [7*DIGITS-1:0] disp;
  logic ovf, use_p, start, pend_wr, start_sign;
  logic [DATA_W-1:0] src_v, start_mag;
  assign use_p = st == CHECK && pend;
  assign start = (update && st == IDLE) || (st == CHECK && (pend || update));
  assign pend_wr = update && (st == SHIFT || use_p);
  assign src_v = use_p ? p_val : value;
  assign start_sign = (use_p ? p_sm : signed_mode) & src_v[DATA_W-1];
  assign start_mag = start_sign ? -src_v : src_v;
  // add 3 to every nibble >= 5 ahead of the shift
  always_comb begin
    adj = bcd;
    for (int n = 0; n < BCD_N; n++)
      adj[4*n+:4] = bcd[4*n+:4] >= 4'd5 ? bcd[4*n+:4] + 4'd3 : bcd[4*n+:4];
  end
  assign nb = {adj[BW-2:0], mag[DATA_W-1]};
  // pad the shifted accumulator so every display digit has a nibble
  always_comb begin
    pb = '0;
    pb[BW-1:0] = nb;
  end
  assign ovf = |(pb >> (4 * (DIGITS - 1)));
`ifdef SEG7_BLANK_LEADING_ZEROS_EN
  assign blk[0] = 1'b0;
  for (genvar i = 1; i < DIGITS - 1; i++) begin : g_blk
    assign blk[i] = ~|pb[4*(DIGITS-1)-1:4*i];
  end
`else
  assign blk = '0;
`endif
  for (genvar i = 0; i < DIGITS - 1; i++) begin : g_enc
    seg7_encode u_enc (.bcd(pb[4*i+:4]), .blank(blk[i]), .seg(enc_flat[7*i+:7]));
  end
  assign disp = {sign ? SEG_MINUS : SEG_BLANK, ovf ? {(DIGITS - 1){SEG_E}} : enc_flat};
  // conversion FSM; the display registers on the final shift so seg and done appear in the CHECK cycle
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= IDLE;
      sign <= 1'b0;
      mag <= '0;
      bcd <= '0;
      cnt <= '0;
      pend <= 1'b0;
      p_val <= '0;
      p_sm <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      overflow <= 1'b0;
      seg <= RST_SEG;
    end else begin
      done <= 1'b0;
      if (pend_wr) begin
        pend <= 1'b1;
        p_val <= value;
        p_sm <= signed_mode;
      end else if (st == CHECK) pend <= 1'b0;
      if (start) begin
        sign <= start_sign;
        mag <= start_mag;
        bcd <= '0;
        cnt <= CW'(DATA_W);
        busy <= 1'b1;
        st <= SHIFT;
      end else if (st == SHIFT) begin
        bcd <= nb;
        mag <= mag << 1;
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          st <= CHECK;
          seg <= disp;
          overflow <= ovf;
          done <= 1'b1;
        end
      end else if (st != IDLE) begin
        st <= IDLE;
        busy <= 1'b0;
      end
    end
endmodule

// File: tb/tb_seg7_display_ctrl.sv
// tb_seg7_display_ctrl: table-driven and sequence checks of the seven-segment controller
module tb_seg7_display_ctrl;
  logic clk = 1'b0, rst = 1'b0, update = 1'b0, signed_mode = 1'b0;
  logic [31:0] value = '0;
  logic [55:0] seg;
  logic busy, done, overflow;
  int passed = 0, total = 0;
  typedef struct {
    logic [31:0] v;
    logic sm;
    bit neg;
    bit ovf;
    longint m;
  } vec_t;
  vec_t tbl[10];
  seg7_display_ctrl #(.DATA_W(32), .DIGITS(8)) dut (
    .clk(clk), .rst(rst), .update(update), .value(value), .signed_mode(signed_mode),
    .seg(seg), .busy(busy), .done(done), .overflow(overflow)
  );
  always #5 clk = ~clk;
  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      default: return 7'b0001100;
    endcase
  endfunction
  function automatic logic [55:0] exp_seg(input bit neg, input bit ovf, input longint m);
    logic [55:0] s;
    longint r;
    r = m;
    s[55:49] = neg ? 7'b1111110 : 7'b1111111;
    for (int i = 0; i < 7; i++) begin
      if (ovf) s[7*i+:7] = 7'b0110000;
      else begin
        s[7*i+:7] = enc(int'(r % 10));
`ifdef SEG7_BLANK_LEADING_ZEROS_EN
        if (i > 0 && r == 0) s[7*i+:7] = 7'b1111111;
`endif
        r = r / 10;
      end
    end
    return s;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask
  task automatic run_vec(input vec_t t);
    int cyc;
    @(posedge clk);
    #1;
    value = t.v;
    signed_mode = t.sm;
    update = 1'b1;
    @(posedge clk);
    #1;
    update = 1'b0;
    chk("busy_start", 64'(busy), 64'd1);
    cyc = 1;
    while (!done && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("latency", 64'(cyc), 64'd33);
    chk("seg", 64'(seg), 64'(exp_seg(t.neg, t.ovf, t.m)));
    chk("overflow", 64'(overflow), 64'(t.ovf));
    @(posedge clk);
    #1;
    chk("done_pulse", 64'(done), 64'd0);
    chk("busy_end", 64'(busy), 64'd0);
  endtask
  task automatic multi(input int t1, input logic [31:0] v1, input int t2, input logic [31:0] v2, input longint e2);
    int ndone;
    logic busy_ok;
    @(posedge clk);
    #1;
    value = 32'd123;
    signed_mode = 1'b1;
    update = 1'b1;
    ndone = 0;
    busy_ok = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk);
      #1;
      update = 1'b0;
      if (c <= 66 && !busy) busy_ok = 1'b0;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          chk("multi_d1_cyc", 64'(c), 64'd33);
          chk("multi_d1_seg", 64'(seg), 64'(exp_seg(0, 0, 123)));
        end else begin
          chk("multi_d2_cyc", 64'(c), 64'd66);
          chk("multi_d2_seg", 64'(seg), 64'(exp_seg(0, 0, e2)));
        end
      end
      if (c == t1) begin
        value = v1;
        update = 1'b1;
      end
      if (c == t2) begin
        value = v2;
        update = 1'b1;
      end
    end
    chk("multi_ndone", 64'(ndone), 64'd2);
    chk("multi_busy_held", 64'(busy_ok), 64'd1);
    chk("multi_busy_end", 64'(busy), 64'd0);
  endtask
  initial begin
    int nd;
    tbl[0] = '{32'd1234,      1'b1, 0, 0, 1234};
    tbl[1] = '{32'hFFFFFFFB,  1'b1, 1, 0, 5};
    tbl[2] = '{32'h80000000,  1'b1, 1, 1, 0};
    tbl[3] = '{32'd9999999,   1'b0, 0, 0, 9999999};
    tbl[4] = '{32'd10000000,  1'b0, 0, 1, 0};
    tbl[5] = '{32'hFFFFFFFB,  1'b0, 0, 1, 0};
    tbl[6] = '{32'd0,         1'b1, 0, 0, 0};
    tbl[7] = '{32'd42,        1'b0, 0, 0, 42};
    tbl[8] = '{32'hFFFFFFFF,  1'b1, 1, 0, 1};
    tbl[9] = '{32'h7FFFFFFF,  1'b1, 0, 1, 0};
    #12;
    chk("rst_seg", 64'(seg), {8'h0, 7'b1111111, {7{7'b0000001}}});
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    rst = 1'b1;
    for (int k = 0; k < 10; k++) run_vec(tbl[k]);
    multi(5, 32'd456, 10, 32'd789, 789);
    multi(33, 32'd77, 0, 32'd0, 77);
    @(posedge clk);
    #1;
    value = 32'd555;
    signed_mode = 1'b0;
    update = 1'b1;
    @(posedge clk);
    #1;
    update = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_seg", 64'(seg), {8'h0, 7'b1111111, {7{7'b0000001}}});
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_overflow", 64'(overflow), 64'd0);
    #2;
    rst = 1'b1;
    nd = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    chk("midrst_no_done", 64'(nd), 64'd0);
    chk("midrst_idle", 64'(busy), 64'd0);
    run_vec(tbl[7]);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
